fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//   Decoupling queue between instruction fetch and decode. Captures {PC, instruction} pairs from fetch.
//   Presents them in order to decode with a valid/ready handshake.
//   in_ready drives the fetch-stage PC write enable: fetch advances only when the queue can accept.
//   flush discards all queued, now-wrong-path entries when the branch mux selects the ALU target.
// PARAMETERS
//   DEPTH    4    entries; power of two, >= 2
//   WORD_W   32   instruction and PC width
// PORTS
//   CLK              in   1       rising-edge clock
//   RST              in   1       asynchronous, active-high reset
//   in_pc            in   WORD_W  PC of the fetched instruction
//   in_instruction   in   WORD_W  instruction word from instruction memory
//   in_valid         in   1       fetch offers an entry this cycle
//   in_ready         out  1       queue accepts this cycle (feeds PC write enable)
//   flush            in   1       taken branch/jump: drop all entries
//   out_pc           out  WORD_W  PC of head entry
//   out_instruction  out  WORD_W  head instruction; NOP_INSTR when out_valid=0
//   out_valid        out  1       head entry present
//   out_ready        in   1       decode consumes head this cycle
//   count            out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   Reset (async assert, sync release)
//     wr_ptr=rd_ptr=0, count=0, out_valid=0, out_pc=0, out_instruction=NOP_INSTR, in_ready=1.
//     Storage contents are not reset.
//   Transfers
//     push = in_valid & in_ready; pop = out_valid & out_ready.
//     Both are evaluated on the same rising CLK edge.
//     in_ready = (count != DEPTH). It is combinational from count only and never depends on out_ready.
//     A full queue therefore refuses a push even when a pop occurs in the same cycle.
//     out_valid = (count != 0). out_pc/out_instruction = storage[rd_ptr] (combinational read of the head).
//   Pointers and count
//     Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
//     count is DEPTH+1-valued (0..DEPTH). push&pop -> count unchanged, both pointers advance.
//   Flush
//     Synchronous and highest priority: next count=0 and wr_ptr=rd_ptr.
//     A push or pop in the flush cycle is discarded; no entry appears after the flush.
//     The cycle after flush: out_valid=0, in_ready=1.
//   Ordering: strict FIFO; no entry is duplicated or lost except by flush.
//   Latency: minimum 1 cycle from push to the entry appearing at out_* (without bypass).
//   Reset mid-operation: all entries are dropped immediately and outputs return to reset values asynchronously.
// CONFIGURATION
//   FETCH_BUFFER_BYPASS_EN defined
//     When count==0 and in_valid and !flush:
//       out_valid=1 and out_pc/out_instruction=in_pc/in_instruction combinationally (0-cycle latency).
//     If out_ready=1 in that cycle, the entry is consumed and not written.
//     If out_ready=0, it is written normally.
//   FETCH_BUFFER_BYPASS_EN undefined
//     out_* are driven only from storage; 1-cycle minimum latency.
// STRUCTURE
//   Shared package processor_pkg: WORD_W default, NOP_INSTR = 32'h0000_0000, typedef fetch_entry_t {pc, instruction}.
//   One sub-module: fetch_buffer_ram (DEPTH x 2*WORD_W).
//     Single write port on CLK, asynchronous read port, no reset.
//   Pointer/count/flush control stays in fetch_buffer.
// TESTING (DEPTH=4, bypass off unless stated)
//   Reset: RST=1 mid-stream with count=3
//     -> out_valid=0, count=0, in_ready=1, out_instruction=0 without waiting for CLK.
//   Fill and drain: push pc 0..3 (instr 32'hA0..A3), out_ready=0
//     -> count=4, in_ready=0.
//     Then out_ready=1 -> out_pc 0,1,2,3 on successive cycles, then out_valid=0.
//   Full plus simultaneous pop: count=4, in_valid=1, out_ready=1
//     -> pop occurs, push refused, count=3.
//     Next cycle in_ready=1 and push accepted.
//   Wrap-around: 10 push/pop pairs at count=2 steady state
//     -> output PC sequence continuous and in order, count stays 2.
//   Flush with push: count=3, flush=1, in_valid=1, in_pc=32'h40
//     -> next cycle count=0, out_valid=0.
//     pc 32'h40 never appears at out_pc.
//   Bypass (FETCH_BUFFER_BYPASS_EN): empty, in_valid=1, in_pc=7, out_ready=1
//     -> out_valid=1, out_pc=7 same cycle; count stays 0.

Source files
------------

// File: rtl/processor_pkg.sv
// processor_pkg: shared fetch-path constants and the {pc, instruction} entry type.
package processor_pkg;
   localparam int DEF_WORD_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   typedef struct packed {
      logic [DEF_WORD_W-1:0] pc;
      logic [DEF_WORD_W-1:0] instruction;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_ram.sv
// fetch_buffer_ram: entry storage, one clocked write port and an asynchronous read port, no reset.
module fetch_buffer_ram #(
   parameter int DEPTH = 4,
   parameter int W = 64
) (
   input  logic                     CLK,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [W-1:0]             o_rdata
);
   logic [W-1:0] r_mem [DEPTH];
   always_ff @(posedge CLK)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch-to-decode FIFO with flush; FETCH_BUFFER_BYPASS_EN enables a 0-cycle empty-queue bypass.
module fetch_buffer
   import processor_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [WORD_W-1:0]        in_pc,
   input  logic [WORD_W-1:0]        in_instruction,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [WORD_W-1:0]        out_pc,
   output logic [WORD_W-1:0]        out_instruction,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [AW:0]         r_count;
   logic                w_has, w_byp, w_push, w_pop, w_wr;
   logic [2*WORD_W-1:0] w_rdata;
   assign w_has    = r_count != '0;
   assign in_ready = r_count != (AW+1)'(DEPTH);
`ifdef FETCH_BUFFER_BYPASS_EN
   assign w_byp = !w_has && in_valid && !flush;
`else
   assign w_byp = 1'b0;
`endif
   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = w_has && out_ready && !flush;
   // a bypassed entry taken by decode in the same cycle never touches storage
   assign w_wr   = w_push && !(w_byp && out_ready);
   assign out_valid       = w_has || w_byp;
   assign out_pc          = w_byp ? in_pc : w_has ? w_rdata[2*WORD_W-1:WORD_W] : '0;
   assign out_instruction = w_byp ? in_instruction : w_has ? w_rdata[WORD_W-1:0] : WORD_W'(NOP_INSTR);
   assign count = r_count;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= r_rd_ptr;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      end
   end
   fetch_buffer_ram #(.DEPTH(DEPTH), .W(2*WORD_W)) u_ram (
      .CLK(CLK),
      .i_we(w_wr),
      .i_waddr(r_wr_ptr),
      .i_wdata({in_pc, in_instruction}),
      .i_raddr(r_rd_ptr),
      .o_rdata(w_rdata)
   );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer (DEPTH=4), directed cases then random traffic.
module tb_fetch_buffer;
   localparam int DEPTH = 4;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] in_pc = '0, in_instruction = '0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_instruction;
   logic [2:0]  count;
   int          n_tests = 0, n_fail = 0;
   logic        saw_40 = 1'b0;
   logic [63:0] q[$];
   fetch_buffer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .in_pc(in_pc), .in_instruction(in_instruction), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush),
      .out_pc(out_pc), .out_instruction(out_instruction), .out_valid(out_valid), .out_ready(out_ready),
      .count(count)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic ordy, input logic fl);
      in_valid = v;
      in_pc = pc;
      in_instruction = ins;
      out_ready = ordy;
      flush = fl;
      @(posedge CLK);
      #1;
   endtask
   // reference model: evaluated mid-cycle, mirrors what the next rising edge will do
   always @(negedge CLK) begin
      if (!RST) begin
         logic ev, er, byp;
         logic [63:0] h;
         byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
         byp = q.size() == 0 && in_valid && !flush;
`endif
         ev = q.size() != 0 || byp;
         er = q.size() != DEPTH;
         check("out_valid", 64'(out_valid), 64'(ev));
         check("in_ready", 64'(in_ready), 64'(er));
         check("count", 64'(count), 64'(q.size()));
         if (!ev) check("nop_when_empty", 64'(out_instruction), 64'h0);
         if (out_valid && out_pc == 32'h40) saw_40 = 1'b1;
         if (flush) q.delete();
         else begin
            if (in_valid && er) q.push_back({in_pc, in_instruction});
            if (ev) begin
               h = q[0];
               check("head_pc", 64'(out_pc), 64'(h[63:32]));
               check("head_instr", 64'(out_instruction), 64'(h[31:0]));
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end
   initial begin
      repeat (2) @(posedge CLK);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      RST = 1'b0;
      // fill to full with decode stalled
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      // full: pop happens, push refused
      step(1'b1, 32'd4, 32'hA4, 1'b1, 1'b0);
      check("full_pop_count", 64'(count), 64'd3);
      check("after_pop_ready", 64'(in_ready), 64'd1);
      step(1'b1, 32'd4, 32'hA4, 1'b0, 1'b0);
      check("refill_count", 64'(count), 64'd4);
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("drained_valid", 64'(out_valid), 64'd0);
      // wrap-around at steady occupancy 2
      step(1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
      step(1'b1, 32'h11, 32'hB1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h12 + 32'(i), 32'hB2 + 32'(i), 1'b1, 1'b0);
         check("wrap_count", 64'(count), 64'd2);
      end
      step(1'b1, 32'h1C, 32'hBC, 1'b0, 1'b0);
      check("pre_flush_count", 64'(count), 64'd3);
      // flush with a simultaneous push and pop
      step(1'b1, 32'h40, 32'hC0, 1'b1, 1'b1);
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ready", 64'(in_ready), 64'd1);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      // first-push latency (bypass when enabled)
      in_valid = 1'b1; in_pc = 32'd7; in_instruction = 32'hD7; out_ready = 1'b1;
      #1;
`ifdef FETCH_BUFFER_BYPASS_EN
      check("byp_valid", 64'(out_valid), 64'd1);
      check("byp_pc", 64'(out_pc), 64'd7);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("byp_count", 64'(count), 64'd0);
`else
      check("lat_valid", 64'(out_valid), 64'd0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("lat_count", 64'(count), 64'd0);
`endif
      // asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 32'hE0 + 32'(i), 1'b0, 1'b0);
      check("pre_rst_count", 64'(count), 64'd3);
      in_valid = 1'b0;
      #1 RST = 1'b1;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_count", 64'(count), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_instr", 64'(out_instruction), 64'd0);
      check("arst_pc", 64'(out_pc), 64'd0);
      q.delete();
      @(posedge CLK);
      #1 RST = 1'b0;
      // random traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 32'h100 + 32'(i), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0);
      check("no_pc40", 64'(saw_40), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
